// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the mesh router.
//   - Output direction encodings (E, W, N, S, Eject) as carried on out_dir.
//   - Flit type codes held in the low two bits of every flit.
//   - Bit offsets of the type and destination fields.
//   - Router FSM state encoding and small helpers for classifying flit types.
package noc_pkg;

  localparam logic [2:0] DIR_E     = 3'd0;
  localparam logic [2:0] DIR_W     = 3'd1;
  localparam logic [2:0] DIR_N     = 3'd2;
  localparam logic [2:0] DIR_S     = 3'd3;
  localparam logic [2:0] DIR_EJECT = 3'd4;

  typedef enum logic [1:0] {
    FT_SINGLE = 2'b00,
    FT_HEAD   = 2'b01,
    FT_BODY   = 2'b10,
    FT_TAIL   = 2'b11
  } flit_type_e;

  localparam int TYPE_W      = 2;
  localparam int TYPE_LSB    = 0;
  localparam int DSTX_LSB    = 2;
  // Offset of the Y field for the default 2-bit coordinate width; routers
  // built with another width use dsty_lsb() instead.
  localparam int NOC_COORD_W = 2;
  localparam int DSTY_LSB    = DSTX_LSB + NOC_COORD_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } ipu_state_e;

  function automatic int dsty_lsb(input int coord_w);
    return DSTX_LSB + coord_w;
  endfunction

  // Flit types that open a packet and therefore carry a routable header.
  function automatic logic starts_packet(input flit_type_e t);
    return (t == FT_SINGLE) || (t == FT_HEAD);
  endfunction

  // Flit types that close a packet and release the route lock.
  function automatic logic ends_packet(input flit_type_e t);
    return (t == FT_SINGLE) || (t == FT_TAIL);
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: small first-word-fall-through flit buffer.
//   clk, reset (async, active-low)
//   push, push_data : write one flit (ignored when full)
//   pop             : discard the head flit (ignored when empty)
//   full, empty     : occupancy flags
//   head            : current head flit, zero when empty
//   count           : number of stored flits
// A flit written on one edge is visible on head only after that edge.
module flit_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  // Storage carries no reset; stale contents are masked by the empty flag.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == AW'(gi))) begin
          mem[gi] <= push_data;
        end
      end
    end
  endgenerate

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/input_port_unit.sv
// input_port_unit: per-input-port front end of the 5-port mesh router.
//   clk, reset (async, active-low)
//   in_flit, in_valid, in_ready : upstream flit interface (in_ready = !full)
//   vc_alloc, out_dir           : one-cycle switch request and its direction
//   ack                         : registered grant for the previous request
//   flit_out                    : FIFO head flit towards the crossbar
//   drop_err                    : sticky flag for discarded orphan flits
// The head flit of each packet is XY-routed; the direction stays locked
// until the flit that closes the packet is popped (wormhole switching).
module input_port_unit
  import noc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 2,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              vc_alloc,
  output logic [2:0]        out_dir,
  input  logic              ack,
  output logic [DATA_W-1:0] flit_out,
  output logic              drop_err
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DY_LSB = dsty_lsb(COORD_W);
  localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              latch_dir;
  logic              drop_set;
  flit_type_e        head_type;
  logic [2:0]        head_route;

  ipu_state_e        state_reg, state_next;
  logic [2:0]        dir_reg;
  logic              drop_err_reg;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  flit_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_flit),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head),
    .count     (fifo_count)
  );

  function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy);
    if (dx > MY_X_C)      return DIR_E;
    else if (dx < MY_X_C) return DIR_W;
    else if (dy > MY_Y_C) return DIR_N;
    else if (dy < MY_Y_C) return DIR_S;
    else                  return DIR_EJECT;
  endfunction

  assign head_type  = flit_type_e'(head[TYPE_LSB +: TYPE_W]);
  assign head_route = xy_route(head[DSTX_LSB +: COORD_W], head[DY_LSB +: COORD_W]);

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    latch_dir  = 1'b0;
    drop_set   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (starts_packet(head_type)) begin
            latch_dir  = 1'b1;
            state_next = ST_REQ;
          end else begin
            // Body/tail with no open packet: nothing to route it by.
            pop      = 1'b1;
            drop_set = 1'b1;
          end
        end
      end
      ST_REQ: state_next = ST_WAIT;
      ST_WAIT: begin
        if (ack) begin
          pop = 1'b1;
          if (ends_packet(head_type))
            state_next = ST_IDLE;
          else if ((fifo_count > CNT_W'(1)) || push)
            state_next = ST_REQ;
          else
            state_next = ST_HOLD;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (!fifo_empty) state_next = ST_REQ;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      dir_reg      <= DIR_E;
      drop_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (latch_dir) dir_reg <= head_route;
      if (drop_set)  drop_err_reg <= 1'b1;
    end
  end

  // Decoded straight from the state register so reset drops it at once.
  assign vc_alloc = (state_reg == ST_REQ);
  assign out_dir  = dir_reg;
  assign flit_out = head;
  assign drop_err = drop_err_reg;

endmodule

// File: tb/tb_input_port_unit.sv
// Directed testbench for input_port_unit at router (1,1), DEPTH=4.
module tb_input_port_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        vc_alloc;
  logic [2:0]  out_dir;
  logic        ack = 1'b0;
  logic [31:0] flit_out;
  logic        drop_err;

  int n_checks = 0;
  int n_errors = 0;
  int ack_en = 1;
  int deny_left = 0;

  input_port_unit #(
    .DATA_W (32), .DEPTH (4), .COORD_W (2), .MY_X (1), .MY_Y (1)
  ) dut (
    .clk      (clk),
    .reset    (reset_n),
    .in_flit  (in_flit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .vc_alloc (vc_alloc),
    .out_dir  (out_dir),
    .ack      (ack),
    .flit_out (flit_out),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the ST controller answers a request seen in the
  // previous cycle with ack in the following cycle, optionally denying.
  task automatic tick();
    logic vc_seen;
    vc_seen = vc_alloc;
    @(posedge clk);
    #1;
    if (vc_seen && (ack_en != 0)) begin
      if (deny_left > 0) begin
        ack = 1'b0;
        deny_left--;
      end else begin
        ack = 1'b1;
      end
    end else begin
      ack = 1'b0;
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [1:0] dx,
                                     input logic [1:0] dy, input logic [25:0] pay);
    return {pay, dy, dx, t};
  endfunction

  logic [31:0] f1;
  logic [31:0] pk[3];
  logic [31:0] pk4[6];
  logic [31:0] exp_flit;
  int exp_vc2[10] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 0};
  int exp_fo2[10] = '{-1, 0, 0, 0, 1, 1, 2, 2, -1, -1};
  int exp_vc3[16] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
  int exp_fo3[16] = '{-1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2, -1, -1};

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int pop_idx;
    logic rdy;

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_vc_alloc", 32'(vc_alloc), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst_out_dir", 32'(out_dir), 32'd0);
    check("rst_flit_out", flit_out, 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);

    // ---- single flit to self -> eject ----
    f1 = mk(2'b00, 2'd1, 2'd1, 26'h00_0A1);
    in_flit = f1; in_valid = 1'b1;
    tick();                                   // E1: push
    in_valid = 1'b0;
    check("t1_vc_c1", 32'(vc_alloc), 32'd0);
    check("t1_flit_c1", flit_out, f1);
    tick();                                   // E2: IDLE->REQ
    check("t1_vc_c2", 32'(vc_alloc), 32'd1);
    check("t1_dir", 32'(out_dir), 32'd4);
    tick();                                   // E3: WAIT, ack offered
    check("t1_vc_c3", 32'(vc_alloc), 32'd0);
    check("t1_ack_c3", 32'(ack), 32'd1);
    tick();                                   // E4: pop
    check("t1_empty", flit_out, 32'd0);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    check("t1_vc_c4", 32'(vc_alloc), 32'd0);
    tick();
    check("t1_idle_vc", 32'(vc_alloc), 32'd0);

    // ---- 3-flit packet to (3,1), always acked ----
    pk[0] = mk(2'b01, 2'd3, 2'd1, 26'h100);
    pk[1] = mk(2'b10, 2'd3, 2'd1, 26'h101);
    pk[2] = mk(2'b11, 2'd3, 2'd1, 26'h102);
    for (int c = 1; c <= 9; c++) begin
      in_valid = (c <= 3);
      in_flit  = (c <= 3) ? pk[c-1] : 32'd0;
      tick();
      check($sformatf("t2_vc_c%0d", c), 32'(vc_alloc), 32'(exp_vc2[c]));
      exp_flit = (exp_fo2[c] < 0) ? 32'd0 : pk[exp_fo2[c]];
      check($sformatf("t2_flit_c%0d", c), flit_out, exp_flit);
      if (exp_vc2[c] == 1) check($sformatf("t2_dir_c%0d", c), 32'(out_dir), 32'd0);
    end
    in_valid = 1'b0;

    // ---- same packet, first three requests denied ----
    deny_left = 3;
    for (int c = 1; c <= 15; c++) begin
      in_valid = (c <= 3);
      in_flit  = (c <= 3) ? pk[c-1] : 32'd0;
      tick();
      check($sformatf("t3_vc_c%0d", c), 32'(vc_alloc), 32'(exp_vc3[c]));
      exp_flit = (exp_fo3[c] < 0) ? 32'd0 : pk[exp_fo3[c]];
      check($sformatf("t3_flit_c%0d", c), flit_out, exp_flit);
    end
    in_valid = 1'b0;

    // ---- backpressure: 6 flits, ack withheld, then drained ----
    pk4[0] = mk(2'b01, 2'd1, 2'd2, 26'h200);
    for (int i = 1; i < 5; i++) pk4[i] = mk(2'b10, 2'd1, 2'd2, 26'(32'h200 + i));
    pk4[5] = mk(2'b11, 2'd1, 2'd2, 26'h205);
    ack_en = 0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (k < 6);
      in_flit  = (k < 6) ? pk4[k] : 32'd0;
      rdy = in_ready;
      tick();
      if (in_valid && rdy) k++;
    end
    check("t4_push_cnt", 32'(k), 32'd4);
    check("t4_in_ready_full", 32'(in_ready), 32'd0);
    check("t4_head_held", flit_out, pk4[0]);
    check("t4_dir", 32'(out_dir), 32'd2);
    ack_en = 1;
    pop_idx = 0;
    for (int c = 0; c < 60 && pop_idx < 6; c++) begin
      in_valid = (k < 6);
      in_flit  = (k < 6) ? pk4[k] : 32'd0;
      rdy = in_ready;
      tick();
      if (in_valid && rdy) k++;
      if (ack) begin
        $display("t4 pop %0d flit=%h", pop_idx, flit_out);
        check($sformatf("t4_pop%0d", pop_idx), flit_out, pk4[pop_idx]);
        pop_idx++;
      end
    end
    in_valid = 1'b0;
    tick();
    check("t4_all_popped", 32'(pop_idx), 32'd6);
    check("t4_all_pushed", 32'(k), 32'd6);
    check("t4_drained", flit_out, 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_dir_held", 32'(out_dir), 32'd2);

    // ---- orphan body flit ----
    f1 = mk(2'b10, 2'd2, 2'd2, 26'h300);
    in_flit = f1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t5_flit", flit_out, f1);
    check("t5_drop_pre", 32'(drop_err), 32'd0);
    tick();
    check("t5_drop_set", 32'(drop_err), 32'd1);
    check("t5_popped", flit_out, 32'd0);
    check("t5_no_vc", 32'(vc_alloc), 32'd0);
    tick();
    tick();
    check("t5_no_vc2", 32'(vc_alloc), 32'd0);
    check("t5_drop_sticky", 32'(drop_err), 32'd1);

    // ---- reset in WAIT of a packet to (1,0) ----
    pk[0] = mk(2'b01, 2'd1, 2'd0, 26'h400);
    pk[1] = mk(2'b10, 2'd1, 2'd0, 26'h401);
    pk[2] = mk(2'b11, 2'd1, 2'd0, 26'h402);
    for (int c = 1; c <= 3; c++) begin
      in_valid = 1'b1;
      in_flit  = pk[c-1];
      tick();
      if (c == 2) check("t6_dir_s", 32'(out_dir), 32'd3);
    end
    in_valid = 1'b0;
    check("t6_wait_vc", 32'(vc_alloc), 32'd0);
    check("t6_wait_head", flit_out, pk[0]);
    #2;
    reset_n = 1'b0;
    ack = 1'b0;
    #1;
    check("t6_rst_vc", 32'(vc_alloc), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);
    check("t6_rst_flush", flit_out, 32'd0);
    check("t6_rst_drop", 32'(drop_err), 32'd0);
    check("t6_rst_dir", 32'(out_dir), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    f1 = mk(2'b00, 2'd0, 2'd1, 26'h500);
    in_flit = f1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t6_post_vc_c1", 32'(vc_alloc), 32'd0);
    tick();
    check("t6_post_vc_c2", 32'(vc_alloc), 32'd1);
    check("t6_post_dir", 32'(out_dir), 32'd1);
    tick();
    tick();
    check("t6_post_empty", flit_out, 32'd0);
    check("t6_post_vc_end", 32'(vc_alloc), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/input_port_unit.md
Name: input_port_unit

Overview:
Per-input-port front end of the 5-port mesh router, one instance each for E, W, N, S and inject.
- Buffers incoming flits in a small FIFO.
- Performs XY route computation on each head flit and holds the resulting 3-bit output direction for the whole packet.
- Drives the vc_alloc/out request pair into the switch-traversal controller and pops one flit per returned ack. Wormhole: the route is locked from head to tail.

Parameters:
DATA_W, 32, flit width including type and destination fields
DEPTH, 4, FIFO entries (power of two, >=2)
COORD_W, 2, width of each X/Y coordinate
MY_X, 0, this router's X coordinate
MY_Y, 0, this router's Y coordinate

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
in_flit  in  DATA_W  incoming flit
in_valid  in  1  in_flit valid this cycle
in_ready  out  1  FIFO can accept; equals !full
vc_alloc  out  1  switch request to the ST controller
out_dir  out  3  requested output: 0=E 1=W 2=N 3=S 4=Eject
ack  in  1  registered grant from the ST controller, refers to the vc_alloc of the previous cycle
flit_out  out  DATA_W  FIFO head flit, to the crossbar
drop_err  out  1  sticky, set when an orphan body/tail flit is discarded

Behaviour:
Flit format:
- [1:0] type: 00 single (head+tail), 01 head, 10 body, 11 tail.
- [2+COORD_W-1:2] dest X; next COORD_W bits dest Y.

Reset values: in_ready=1, vc_alloc=0, out_dir=0, flit_out=0 when empty, drop_err=0, FIFO count=0, state=IDLE.

FIFO:
- Push when in_valid && in_ready.
- Pop per state machine below.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- No bypass: a flit pushed at edge t is first visible on flit_out after edge t.

Routing (XY, combinational on FIFO head):
- dest X > MY_X -> 0; dest X < MY_X -> 1.
- Otherwise dest Y > MY_Y -> 2; dest Y < MY_Y -> 3.
- Otherwise 4.
- Latched into out_dir on the IDLE->REQ transition; held until the tail pops.

State machine (IDLE, REQ, WAIT, HOLD):
- IDLE, FIFO empty: stay.
- IDLE, head is type 00/01: latch route, go to REQ.
- IDLE, head is type 10/11: pop it, set drop_err, stay in IDLE.
- REQ: vc_alloc=1 for exactly one cycle, then go to WAIT.
- WAIT: vc_alloc=0.
  - ack=0: return to REQ.
  - ack=1: pop the head flit. If the popped flit is type 00/11, go to IDLE. Else if FIFO will be non-empty after the pop (including a same-cycle push), go to REQ. Else go to HOLD.
- HOLD: FIFO non-empty -> REQ; otherwise stay. out_dir stays latched.
- A head-type flit found mid-packet is forwarded as a body flit; it is not re-routed.
- Consequences:
  - At most one request is outstanding at a time.
  - Throughput is 1 flit per 2 cycles.
  - Latency from head arrival to first vc_alloc is 2 cycles: push edge, then IDLE->REQ edge.
- ack arriving outside WAIT is ignored.
- flit_out is stable throughout REQ and WAIT; the crossbar samples it on the edge that ends a WAIT cycle with ack=1.
- Reset asserted mid-packet flushes the FIFO, drops the packet and returns to IDLE with vc_alloc=0 asynchronously.

Decomposition:
- Shared package noc_pkg holds:
  - Direction constants DIR_E=0, DIR_W=1, DIR_N=2, DIR_S=3, DIR_EJECT=4.
  - Flit type codes.
  - Field offsets TYPE_LSB=0, DSTX_LSB=2, DSTY_LSB=2+COORD_W.
- One sub-module: flit_fifo (parameterised DATA_W/DEPTH, push/pop/full/empty/head).
- Route function and FSM stay in input_port_unit.

Test Plan:
- MY=(1,1), single flit type 00 dest (1,1), ack=1 one cycle after vc_alloc -> out_dir=4; vc_alloc high 1 cycle, 2 cycles after push; FIFO empty after ack edge; state IDLE.
- 3-flit packet head/body/tail dest (3,1), ack always returned -> out_dir=0 for all three; vc_alloc pulses at cycles 2, 4, 6; tail pop returns to IDLE.
- Same packet with ack=0 for first 3 requests -> vc_alloc repeats every 2 cycles; flit_out holds the head flit; no pop until the 4th request is acked.
- DEPTH=4, ack held 0, 6 flits offered back-to-back -> in_ready drops after 4 pushes; flits 5-6 held upstream; no overwrite or loss.
- Body flit (type 10) at head in IDLE -> popped without vc_alloc; drop_err=1 and stays 1 until reset.
- Reset low during WAIT of a 3-flit packet -> vc_alloc=0 and in_ready=1 immediately; after release the next head dest (0,1) routes out_dir=1.
